rmii_mdio_ctrl: RTL and testbench
=================================

# rmii_mdio_ctrl

MDIO management master that configures and monitors the external RMII PHY through its clause-22 register set. It sits beside the RMII/MII datapath in the Ethernet subsystem and serialises single register read/write commands onto MDC/MDIO. It returns read data and a no-PHY error flag. It holds one command at a time and applies backpressure with a valid/ready handshake.

## Interface
- CLK_DIV, 20: half-period of MDC in clk_int cycles; MDC period = 2*CLK_DIV. Minimum 2.
- PREAMBLE_EN, 1: 1 = send a 32-bit all-ones preamble; 0 = suppress the preamble.

- clk_int  in  1  system clock; every register uses this clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE; the command is accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_phy_addr  in  5  PHY address.
- cmd_reg_addr  in  5  register address.
- cmd_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle pulse when a frame completes.
- rsp_rdata  out  16  read data; holds its value until the next read completes.
- rsp_error  out  1  valid with rsp_valid; 1 = the PHY did not drive TA low during a read.
- busy  out  1  high whenever the block is not in IDLE.
- mdc  out  1  management clock.
- mdio_o  out  1  MDIO output data.
- mdio_oe  out  1  MDIO output enable; 0 = tri-stated.
- mdio_i  in  1  MDIO input, externally pulled up.

## Operation
- States and transitions:
  - IDLE: cmd_ready=1. On accept, latch all cmd_* fields and go to PRE, or to HDR when PREAMBLE_EN=0.
  - PRE: 32 bits of 1.
  - HDR: 14 bits. ST=01; OP=01 for write, 10 for read; PHYAD[4:0] then REGAD[4:0], MSB first.
  - TA: 2 bits. Write drives 1,0. Read releases the bus (mdio_oe=0).
  - DATA: 16 bits, MSB first. Write drives wdata. Read keeps mdio_oe=0 and shifts mdio_i into a shift register.
  - DONE: single cycle. mdio_oe=0, rsp_valid=1, then back to IDLE.
- Frame length N = 64 bits with PREAMBLE_EN=1, 32 bits with PREAMBLE_EN=0.
- Divider counter div_cnt runs 0..CLK_DIV-1 and is active only outside IDLE. MDC toggles when div_cnt wraps.
- Each bit period is an MDC-low half followed by an MDC-high half.
  - mdio_o and mdio_oe update at the start of the low half.
  - mdio_i is sampled on the clk_int cycle where mdc goes 0->1.
- Read, second TA bit: sample mdio_i. If it is 1, rsp_error=1. The frame still runs to completion and data is still captured (typically 0xFFFF).
- rsp_rdata loads the shift register only at DONE of a read. Writes leave rsp_rdata unchanged and report rsp_error=0.
- cmd_valid while busy: ignored (cmd_ready=0). Command fields may change freely while the block is busy.
- Reset values: mdc=0, mdio_o=1, mdio_oe=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, state=IDLE, div_cnt=0.
- Reset asserted mid-frame: all outputs return to their reset values immediately. No rsp_valid is produced and the command is dropped.

## Timing
- Accept at cycle T. At T+1: state is PRE/HDR, busy=1, mdio_oe=1 with the first bit on mdio_o, mdc=0.
- mdc first rises at T+1+CLK_DIV. Bit k starts at T+1+k*2*CLK_DIV.
- rsp_valid is high at cycle T+1+N*2*CLK_DIV, with mdc=0 and mdio_oe=0. cmd_ready is high on the following cycle.
- Back-to-back minimum spacing: next accept at T+2+N*2*CLK_DIV.
- For a read, mdio_oe falls at the start of TA bit 0. Frame bit index 46 with preamble, 14 without.
- For a write, mdio_oe stays high through the last data bit.
- mdc duty cycle is exactly 50%. No glitches on mdc; it is a registered output.

## Test plan
- Write, CLK_DIV=4, PREAMBLE_EN=1, phy=1, reg=0, wdata=0x1140 -> mdio_o sequence 32×1, 0101, 00001, 00000, 10, 0001000101000000 on mdc low halves. rsp_valid at T+513, rsp_error=0.
- Read, phy=1, reg=2; PHY model drives TA 0 then 0x796D -> mdio_oe=0 from bit 46. rsp_rdata=0x796D, rsp_error=0, rsp_valid at T+513.
- Read with no PHY (mdio_i held 1) -> rsp_rdata=0xFFFF, rsp_error=1. A following write reports rsp_error=0 and rsp_rdata stays 0xFFFF.
- cmd_valid held high across two commands -> second accept exactly one cycle after the first rsp_valid. No command is accepted while busy=1.
- reset_n pulsed low at bit 20 of a write -> mdc=0, mdio_oe=0, mdio_o=1 in the same cycle. No rsp_valid. A new command after release runs a full frame.
- PREAMBLE_EN=0, CLK_DIV=2, read -> 32-bit frame, rsp_valid at T+129, mdio_oe falls at bit 14.

Source files
------------

// File: rtl/rmii_mdio_ctrl.sv
// Clause-22 MDIO management master: serialises one register read/write at a time onto MDC/MDIO
// and returns read data plus a no-PHY error flag.
module rmii_mdio_ctrl #(
   parameter int unsigned CLK_DIV     = 20,
   parameter bit          PREAMBLE_EN = 1'b1
) (
   input  logic        clk_int,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [4:0]  cmd_phy_addr,
   input  logic [4:0]  cmd_reg_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_error,
   output logic        busy,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i
);

   localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned FRAME_W = 64;
   localparam int unsigned SEG_W   = 5;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_HDR  = 3'd2;
   localparam logic [2:0] S_TA   = 3'd3;
   localparam logic [2:0] S_DATA = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]         state_q, state_d, nxt;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [SEG_W-1:0]   cnt_q, cnt_d, seg_last;
   logic [FRAME_W-1:0] frame_q, frame_d, frame_ld;
   logic [31:0]        hdr;
   logic [15:0]        shreg_q, shreg_d, rdata_q, rdata_d;
   logic               mdc_q, mdc_d, write_q, write_d, err_q, err_d;
   logic               mdio_o_q, mdio_o_d, mdio_oe_q, mdio_oe_d;
   logic               rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic               ready_q, ready_d, busy_q, busy_d, wrap;

   // Next-state logic: one frame bit per MDC period, outputs change at the start of the low half
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      frame_d     = frame_q;
      shreg_d     = shreg_q;
      rdata_d     = rdata_q;
      mdc_d       = mdc_q;
      write_d     = write_q;
      err_d       = err_q;
      mdio_o_d    = mdio_o_q;
      mdio_oe_d   = mdio_oe_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      nxt         = state_q;
      seg_last    = '0;
      wrap        = (div_q == DIV_W'(CLK_DIV - 1));
      // Read frames load ones in TA/DATA; the bus is released there so the value is don't-care
      hdr      = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr,
                  (cmd_write ? 2'b10 : 2'b11), (cmd_write ? cmd_wdata : 16'hFFFF)};
      frame_ld = PREAMBLE_EN ? {32'hFFFF_FFFF, hdr} : {hdr, 32'hFFFF_FFFF};

      case (state_q)
         S_IDLE: begin
            div_d = '0;
            mdc_d = 1'b0;
            if (cmd_valid) begin
               state_d   = PREAMBLE_EN ? S_PRE : S_HDR;
               cnt_d     = '0;
               write_d   = cmd_write;
               err_d     = 1'b0;
               mdio_o_d  = frame_ld[FRAME_W-1];
               mdio_oe_d = 1'b1;
               frame_d   = {frame_ld[FRAME_W-2:0], 1'b1};
            end
         end
         S_PRE, S_HDR, S_TA, S_DATA: begin
            div_d = wrap ? '0 : div_q + DIV_W'(1);
            if (wrap) mdc_d = ~mdc_q;
            case (state_q)
               S_PRE:   seg_last = SEG_W'(31);
               S_HDR:   seg_last = SEG_W'(13);
               S_TA:    seg_last = SEG_W'(1);
               default: seg_last = SEG_W'(15);
            endcase
            // Sample on the MDC rising transition
            if (wrap && !mdc_q && !write_q) begin
               if (state_q == S_TA && cnt_q == SEG_W'(1)) err_d = mdio_i;
               if (state_q == S_DATA) shreg_d = {shreg_q[14:0], mdio_i};
            end
            if (wrap && mdc_q) begin
               if (cnt_q == seg_last) begin
                  cnt_d = '0;
                  case (state_q)
                     S_PRE:   nxt = S_HDR;
                     S_HDR:   nxt = S_TA;
                     S_TA:    nxt = S_DATA;
                     default: nxt = S_DONE;
                  endcase
               end else begin
                  cnt_d = cnt_q + SEG_W'(1);
               end
               state_d = nxt;
               if (nxt == S_DONE) begin
                  mdio_o_d    = 1'b1;
                  mdio_oe_d   = 1'b0;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = ~write_q & err_q;
                  if (!write_q) rdata_d = shreg_q;
               end else begin
                  mdio_o_d  = frame_q[FRAME_W-1];
                  frame_d   = {frame_q[FRAME_W-2:0], 1'b1};
                  mdio_oe_d = write_q || (nxt == S_PRE) || (nxt == S_HDR);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            div_d   = '0;
            mdc_d   = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_IDLE);
      busy_d  = ~ready_d;
   end

   always_ff @(posedge clk_int or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         cnt_q       <= '0;
         frame_q     <= '1;
         shreg_q     <= '0;
         rdata_q     <= '0;
         mdc_q       <= 1'b0;
         write_q     <= 1'b0;
         err_q       <= 1'b0;
         mdio_o_q    <= 1'b1;
         mdio_oe_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         frame_q     <= frame_d;
         shreg_q     <= shreg_d;
         rdata_q     <= rdata_d;
         mdc_q       <= mdc_d;
         write_q     <= write_d;
         err_q       <= err_d;
         mdio_o_q    <= mdio_o_d;
         mdio_oe_q   <= mdio_oe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
      end
   end

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_error = rsp_err_q;
   assign mdc       = mdc_q;
   assign mdio_o    = mdio_o_q;
   assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_rmii_mdio_ctrl.sv
// Bench for rmii_mdio_ctrl: random commands against a clause-22 PHY model, scoreboarded responses
// and per-bit frame capture; a second no-preamble instance covers the short frame.
module tb_rmii_mdio_ctrl;

   localparam int unsigned CD1  = 4;
   localparam int unsigned N1   = 64;
   localparam int unsigned BP1  = 2 * CD1;
   localparam logic [4:0]  PHYA = 5'd1;

   typedef struct {
      int          t_acc;
      int          t_rsp;
      logic [15:0] rdata;
      logic        err;
      logic [63:0] fo;
      logic [63:0] foe;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_valid2 = 1'b0, cmd_write = 1'b0;
   logic [4:0]  cmd_phy_addr = '0, cmd_reg_addr = '0;
   logic [15:0] cmd_wdata = '0;
   logic        mdio_i1 = 1'b1, mdio_i2 = 1'b1;
   logic        cmd_ready1, rsp_valid1, rsp_error1, busy1, mdc1, mdio_o1, mdio_oe1;
   logic        cmd_ready2, rsp_valid2, rsp_error2, busy2, mdc2, mdio_o2, mdio_oe2;
   logic [15:0] rsp_rdata1, rsp_rdata2;

   rmii_mdio_ctrl #(.CLK_DIV(CD1), .PREAMBLE_EN(1'b1)) u_dut (
      .clk_int(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
      .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
      .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
      .rsp_error(rsp_error1), .busy(busy1), .mdc(mdc1), .mdio_o(mdio_o1),
      .mdio_oe(mdio_oe1), .mdio_i(mdio_i1));

   rmii_mdio_ctrl #(.CLK_DIV(2), .PREAMBLE_EN(1'b0)) u_dut2 (
      .clk_int(clk), .reset_n(reset_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
      .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
      .rsp_error(rsp_error2), .busy(busy2), .mdc(mdc2), .mdio_o(mdio_o2),
      .mdio_oe(mdio_oe2), .mdio_i(mdio_i2));

   int          n_chk = 0, n_err = 0, viol = 0;
   exp_t        exp_q[$];
   logic [15:0] model_regs [32];
   logic [15:0] phy_regs [32];
   logic [15:0] last_rdata = '0;
   logic        phy_en = 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Clause-22 PHY at address PHYA: decodes frames on MDC rising edges, answers reads, stores writes
   int          ph = 0, ones = 0, hn = 0, m = 0;
   logic [11:0] hbuf = '0;
   logic [17:0] wbuf = '0;
   logic [4:0]  pa_l = '0, ra_l = '0;
   logic [15:0] rdv = '0;
   logic        line;
   always @(posedge mdc1 or negedge reset_n) begin
      if (!reset_n) begin
         ph = 0; ones = 0; mdio_i1 = 1'b1;
      end else begin
         line = mdio_oe1 ? mdio_o1 : mdio_i1;
         case (ph)
            0: if (line) ones++;
               else begin
                  if (ones >= 32) ph = 1;
                  ones = 0;
               end
            1: if (line) begin ph = 2; hn = 0; end else ph = 0;
            2: begin
               hbuf = {hbuf[10:0], line};
               hn++;
               if (hn == 12) begin
                  pa_l = hbuf[9:5];
                  ra_l = hbuf[4:0];
                  if (hbuf[11:10] == 2'b10 && phy_en && pa_l == PHYA) begin
                     ph = 3; m = 0; rdv = phy_regs[ra_l];
                  end else if (hbuf[11:10] == 2'b01) begin
                     ph = 4; hn = 0;
                  end else ph = 0;
               end
            end
            3: begin
               if (m == 0) mdio_i1 = 1'b0;
               else if (m <= 16) mdio_i1 = rdv[16-m];
               else begin mdio_i1 = 1'b1; ph = 0; end
               m++;
            end
            default: begin
               wbuf = {wbuf[16:0], line};
               hn++;
               if (hn == 18) begin
                  if (phy_en && pa_l == PHYA && wbuf[17:16] == 2'b10) phy_regs[ra_l] = wbuf[15:0];
                  ph = 0;
               end
            end
         endcase
      end
   end

   // Frame capture and scoreboard monitor
   logic        busy_prev = 1'b0, chk_next = 1'b0;
   int          cap_start = 0;
   logic [63:0] cap_o = '0, cap_oe = '0, cap_mlo = '0, cap_mhi = '0;
   always @(negedge clk) begin : mon
      exp_t e;
      int off, b, r;
      if (!reset_n) begin
         chk_next  = 1'b0;
         busy_prev = 1'b0;
      end else begin
         if (busy1 && !busy_prev) begin
            cap_start = cyc; cap_o = '0; cap_oe = '0; cap_mlo = '1; cap_mhi = '0;
         end
         busy_prev = busy1;
         if (busy1) begin
            off = cyc - cap_start;
            if (off < int'(N1 * BP1)) begin
               b = off / int'(BP1);
               r = off % int'(BP1);
               if (r == 0) begin
                  cap_o[63-b] = mdio_o1; cap_oe[63-b] = mdio_oe1; cap_mlo[63-b] = mdc1;
               end
               if (r == int'(CD1)) cap_mhi[63-b] = mdc1;
            end
         end
         if (cmd_ready1 === busy1) viol++;
         if (chk_next) begin
            chk("after_rsp_ready_pulse", {62'd0, cmd_ready1, rsp_valid1}, 64'b10);
            chk_next = 1'b0;
         end
         if (rsp_valid1) begin
            chk_next = 1'b1;
            if (exp_q.size() == 0) chk("unexpected_rsp_valid", 64'd1, 64'd0);
            else begin
               e = exp_q.pop_front();
               chk("rsp_time", 64'(cyc), 64'(e.t_rsp));
               chk("first_bit_time", 64'(cap_start), 64'(e.t_acc + 1));
               chk("rsp_error", 64'(rsp_error1), 64'(e.err));
               chk("rsp_rdata", 64'(rsp_rdata1), 64'(e.rdata));
               chk("done_mdc_oe", {62'd0, mdc1, mdio_oe1}, 64'd0);
               chk("frame_mdio_o", cap_o & e.foe, e.fo & e.foe);
               chk("frame_mdio_oe", cap_oe, e.foe);
               chk("mdc_low_halves", cap_mlo, 64'd0);
               chk("mdc_high_halves", cap_mhi, {64{1'b1}});
            end
         end
      end
   end

   // Drive one command, model its expected response and frame, push to the scoreboard
   task automatic issue(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, input bit keep, output int t_acc);
      exp_t e;
      int   k = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_phy_addr = pa; cmd_reg_addr = ra; cmd_wdata = wd;
      while (!cmd_ready1 && k < 2000) begin @(negedge clk); k++; end
      t_acc = cyc;
      if (!cmd_ready1) begin
         chk("accept_timeout", 64'd0, 64'd1);
         cmd_valid = 1'b0;
         return;
      end
      e.t_acc = t_acc;
      e.t_rsp = t_acc + 1 + int'(N1 * BP1);
      if (wr) begin
         if (phy_en && pa == PHYA) model_regs[ra] = wd;
         e.rdata = last_rdata; e.err = 1'b0;
      end else if (phy_en && pa == PHYA) begin
         e.rdata = model_regs[ra]; e.err = 1'b0;
      end else begin
         e.rdata = 16'hFFFF; e.err = 1'b1;
      end
      last_rdata = e.rdata;
      e.fo  = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), pa, ra, (wr ? 2'b10 : 2'b00),
               (wr ? wd : 16'h0000)};
      e.foe = wr ? {64{1'b1}} : {{46{1'b1}}, 18'd0};
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (!keep) cmd_valid = 1'b0;
      cmd_write = 1'($urandom); cmd_phy_addr = 5'($urandom);
      cmd_reg_addr = 5'($urandom); cmd_wdata = 16'($urandom);
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((exp_q.size() != 0 || busy1) && k < 3000) begin @(negedge clk); k++; end
      if (exp_q.size() != 0 || busy1) chk("idle_timeout", 64'd1, 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          t1, t2, t0, c, b;
      logic        wr, got;
      logic [4:0]  pa, ra;
      logic [15:0] wd, d2, sv_last;
      logic [15:0] sv_regs [32];
      logic [31:0] oe2v;
      bit          keep;
      for (int i = 0; i < 32; i++) begin
         wd = 16'($urandom);
         phy_regs[i] = wd; model_regs[i] = wd;
      end
      phy_regs[2] = 16'h796D; model_regs[2] = 16'h796D;

      repeat (2) @(negedge clk);
      chk("rst_mdc_mdio_oe", {61'd0, mdc1, mdio_o1, mdio_oe1}, 64'b010);
      chk("rst_ready_busy_valid", {61'd0, cmd_ready1, busy1, rsp_valid1}, 64'b100);
      chk("rst_rdata_error", {47'd0, rsp_rdata1, rsp_error1}, 64'd0);
      chk("rst2_outputs", {58'd0, mdc2, mdio_o2, mdio_oe2, cmd_ready2, busy2, rsp_valid2}, 64'b010100);
      reset_n = 1'b1;

      issue(1'b1, PHYA, 5'd0, 16'h1140, 1'b0, t1);
      issue(1'b0, PHYA, 5'd2, 16'h0000, 1'b0, t1);
      wait_idle();

      phy_en = 1'b0;
      issue(1'b0, PHYA, 5'd2, 16'h0000, 1'b0, t1);
      wait_idle();
      phy_en = 1'b1;
      issue(1'b1, PHYA, 5'd4, 16'($urandom), 1'b0, t1);
      wait_idle();

      // cmd_valid held across two commands
      issue(1'b0, PHYA, 5'd0, 16'h0000, 1'b1, t1);
      issue(1'b1, PHYA, 5'd7, 16'($urandom), 1'b0, t2);
      chk("back_to_back_spacing", 64'(t2 - t1), 64'(N1 * BP1 + 2));
      wait_idle();

      for (int i = 0; i < 14; i++) begin
         wr   = 1'($urandom);
         pa   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : PHYA;
         ra   = 5'($urandom_range(0, 7));
         wd   = 16'($urandom);
         keep = (i < 13) && ($urandom_range(0, 2) == 0);
         issue(wr, pa, ra, wd, keep, t1);
      end
      wait_idle();
      for (int i = 0; i < 8; i++) issue(1'b0, PHYA, 5'(i), 16'h0000, 1'b0, t1);
      wait_idle();

      // Reset in the middle of a write: immediate return to reset values, command dropped
      sv_regs = model_regs; sv_last = last_rdata;
      issue(1'b1, PHYA, 5'd0, 16'hBEEF, 1'b0, t1);
      while (cyc < t1 + 1 + 20 * int'(BP1) + 3) @(negedge clk);
      chk("abort_busy_before", 64'(busy1), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_mdc_oe_o", {61'd0, mdc1, mdio_oe1, mdio_o1}, 64'b001);
      chk("abort_ready_busy_valid", {61'd0, cmd_ready1, busy1, rsp_valid1}, 64'b100);
      exp_q.delete();
      model_regs = sv_regs; last_rdata = sv_last;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      issue(1'b0, PHYA, 5'd0, 16'h0000, 1'b0, t1);
      wait_idle();

      // No-preamble instance, CLK_DIV=2: 32-bit read frame driven bit by bit
      d2 = 16'($urandom);
      @(negedge clk);
      cmd_write = 1'b0; cmd_phy_addr = PHYA; cmd_reg_addr = 5'd3; cmd_valid2 = 1'b1;
      chk("dut2_ready", 64'(cmd_ready2), 64'd1);
      t0 = cyc;
      @(posedge clk); #1;
      cmd_valid2 = 1'b0;
      oe2v = '0; got = 1'b0; t2 = 0;
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         c = cyc - t0 - 1;
         if (c >= 0 && c < 128 && (c % 4) == 0) begin
            b = c / 4;
            oe2v[31-b] = mdio_oe2;
            mdio_i2 = (b == 15) ? 1'b0 : (b >= 16) ? d2[31-b] : 1'b1;
         end
         if (rsp_valid2) begin got = 1'b1; t2 = cyc; end
      end
      mdio_i2 = 1'b1;
      chk("dut2_rsp_seen", 64'(got), 64'd1);
      chk("dut2_rsp_time", 64'(t2), 64'(t0 + 129));
      chk("dut2_rdata", 64'(rsp_rdata2), 64'(d2));
      chk("dut2_error", 64'(rsp_error2), 64'd0);
      chk("dut2_oe_profile", 64'(oe2v), 64'({{14{1'b1}}, 18'd0}));
      repeat (4) @(negedge clk);

      chk("ready_busy_exclusive", 64'(viol), 64'd0);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
